wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
Final pipeline stage. It accepts the memory-stage bundle (ms_to_ws_bus) and commits the GPR write-back. It owns the CP0 exception/status registers and raises the flush (WS_EX / ERET) and redirect signals to the earlier stages. Its forwarding and dependence outputs feed the decode stage.

Parameters:
EX_ENTRY, 32'hbfc00380, exception vector driven on ws_redirect_pc when WS_EX
MS_TO_WS_BUS_WD, 119, input bus width (from shared header)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ms_to_ws_valid  in  1  memory stage presents a valid bundle
ms_to_ws_bus  in  119  {rd[118:114], tlbr, tlbwi, mfc0, mtc0, pc_error, BadVAddr[108:77], ex_code[76:72], eret, slot, gr_we, dest[68:64], final_result[63:32], pc[31:0]}
ws_allowin  out  1  stage can accept a bundle
rf_we  out  1  GPR write enable
rf_waddr  out  5  GPR write address
rf_wdata  out  32  GPR write data
WB_dest  out  5  dest for dependence check; 0 when invalid
WB_dest_data  out  32  forwarding data
WS_EX  out  1  exception committed this cycle; flushes earlier stages
ERET  out  1  eret committed this cycle
ws_redirect_pc  out  32  EX_ENTRY when WS_EX, EPC when ERET
int_pending  out  1  enabled interrupt pending, to decode stage
inst_mfc0_ws  out  1  valid mfc0 in WB, for dependence check

Behaviour:
- Ready/valid: ws_ready_go is always 1 and ws_allowin is always 1. ws_valid and bus_r load on ms_to_ws_valid && ws_allowin.
- Reset: ws_valid=0; bus_r cleared except ex_code=NO_EX (5'h1f); Status=32'h0040_0000 (BEV); Cause=0; EPC=0; BadVAddr=0; all outputs 0.
- Flush: a cycle with WS_EX or ERET high clears ws_valid on the next edge. That cycle also blocks the load of a new bundle.
- Derived outputs:
  - WS_EX = ws_valid && ex_code != NO_EX.
  - ERET = ws_valid && eret && !WS_EX.
  - rf_we = ws_valid && gr_we && !WS_EX.
  - rf_waddr = dest.
  - rf_wdata = mfc0 ? cp0_rdata(rd) : final_result.
  - WB_dest = dest & {5{ws_valid && gr_we}}.
  - WB_dest_data = rf_wdata.
- CP0 write priority, highest first: reset > WS_EX > ERET > mtc0.
- On WS_EX:
  - If Status.EXL == 0: EPC <= slot ? pc-4 : pc, and Cause.BD <= slot.
  - If Status.EXL == 1: EPC and Cause.BD are held.
  - Always: Status.EXL <= 1 and Cause.ExcCode[6:2] <= ex_code.
  - If ex_code is AdEL (4) or AdES (5): BadVAddr <= (pc_error ? pc : BadVAddr field).
- On ERET: Status.EXL <= 0.
- mtc0 (ws_valid && !WS_EX), data = final_result:
  - rd 12 writes IM[15:8], EXL[1], IE[0].
  - rd 13 writes IP[9:8] only.
  - rd 14 writes all 32 bits of EPC.
  - Other rd values are ignored.
- mfc0 read: Status, Cause, EPC, BadVAddr; any other rd returns 0.
- int_pending = |(Cause.IP & Status.IM) && Status.IE && !Status.EXL. It is combinational from the registers.
- tlbr/tlbwi: carried through, no effect in this block. They are reserved for the TLB unit.

Optional Feature:
CP0_TIMER_EN.
- Defined:
  - Count (rd 9) increments every second cycle via a toggle bit.
  - Compare is rd 11.
  - Count == Compare sets Cause.TI and Cause.IP[7].
  - An mtc0 to Compare clears TI.
  - mtc0/mfc0 to rd 9 and rd 11 are enabled.
- Undefined: no Count/Compare registers; TI and IP[7] read 0; rd 9 and rd 11 read 0.

Decomposition:
- The shared header holds NO_EX, the ExcCode constants (INT 0, AdEL 4, AdES 5, SYS 8, BP 9, RI 10, OV 12), the CP0 register numbers and MS_TO_WS_BUS_WD.
- One sub-module, wb_cp0. It contains the CP0 registers, the read mux and the timer logic. The wb_stage top keeps the pipeline register and the GPR commit.

Test Plan:
- ALU result pc=0xbfc00010, dest=5, gr_we=1, value 0x1234 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, WB_dest=5.
- SYS (ex 8) at pc=0x80 with slot=0, gr_we=1 -> WS_EX=1 and rf_we=0 that cycle; next cycle EPC=0x80, ExcCode=8, EXL=1, ws_valid=0; ws_redirect_pc=0xbfc00380.
- AdEL with slot=1, pc=0x104, BadVAddr=0x1001 -> EPC=0x100, BD=1, BadVAddr=0x1001. A second exception while EXL=1 leaves EPC and BD unchanged.
- mtc0 rd=14 with 0x2000, then eret -> next cycle ERET=1 with ws_redirect_pc=0x2000; the following cycle EXL=0.
- mtc0 Status=0x0000_0301, then mtc0 Cause IP[8]=1 -> int_pending=1. Setting EXL -> int_pending=0.
- CP0_TIMER_EN: Compare=4, Count=0 -> TI=1 after 8 cycles. An mtc0 to Compare clears TI. mfc0 rd 9 returns the running Count.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared constants and memory-to-writeback bus layout
// Holds the "no exception" marker, the ExcCode values, the CP0 register
// numbers, the bus width and the packed view of ms_to_ws_bus.
package wb_stage_pkg;
    localparam int MS_TO_WS_BUS_WD = 119;

    localparam logic [4:0] NO_EX    = 5'h1f;
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    typedef struct packed {
        logic [4:0]  rd;
        logic        tlbr;
        logic        tlbwi;
        logic        mfc0;
        logic        mtc0;
        logic        pc_error;
        logic [31:0] badvaddr;
        logic [4:0]  ex_code;
        logic        eret;
        logic        slot;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_bus_t;

    // Cleared bundle with ex_code parked at NO_EX so an empty stage never
    // looks like a pending exception.
    localparam ms_bus_t BUS_RST = ms_bus_t'({42'd0, NO_EX, 72'd0});
endpackage

// File: rtl/wb_cp0.sv
// wb_cp0: CP0 Status/Cause/EPC/BadVAddr registers, read mux, optional timer
// Ports: clk, reset (sync, active-high); ws_ex/eret commit strobes; mtc0_we
// with rd/wdata; exception info ex_code/slot/pc/pc_error/badvaddr;
// outputs rdata (mfc0 read of rd), epc, int_pending.
// Optional feature: CP0_TIMER_EN adds Count (rd 9) and Compare (rd 11).
module wb_cp0
    import wb_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ws_ex,
    input  logic        eret,
    input  logic        mtc0_we,
    input  logic [4:0]  rd,
    input  logic [31:0] wdata,
    input  logic [4:0]  ex_code,
    input  logic        slot,
    input  logic [31:0] pc,
    input  logic        pc_error,
    input  logic [31:0] badvaddr,
    output logic [31:0] rdata,
    output logic [31:0] epc,
    output logic        int_pending
);
    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d, ie_q, ie_d, bd_q, bd_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  exc_q, exc_d;
    logic [31:0] epc_q, epc_d, bva_q, bva_d;
    logic [31:0] status, cause, count_rd, compare_rd;
    logic        ti, mt_status, mt_cause, mt_epc;

`ifdef CP0_TIMER_EN
    logic        tick_q, tick_d, ti_q, ti_d;
    logic [31:0] count_q, count_d, compare_q, compare_d;
    always_comb begin
        tick_d    = ~tick_q;
        count_d   = mtc0_we && rd == CP0_COUNT ? wdata : count_q + {31'd0, tick_q};
        compare_d = mtc0_we && rd == CP0_COMPARE ? wdata : compare_q;
        ti_d      = mtc0_we && rd == CP0_COMPARE ? 1'b0 : ti_q || count_q == compare_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q    <= 1'b0;
            ti_q      <= 1'b0;
            count_q   <= '0;
            compare_q <= '0;
        end else begin
            tick_q    <= tick_d;
            ti_q      <= ti_d;
            count_q   <= count_d;
            compare_q <= compare_d;
        end
    end
    assign ti         = ti_q;
    assign count_rd   = count_q;
    assign compare_rd = compare_q;
`else
    assign ti         = 1'b0;
    assign count_rd   = '0;
    assign compare_rd = '0;
`endif

    assign mt_status = mtc0_we && rd == CP0_STATUS;
    assign mt_cause  = mtc0_we && rd == CP0_CAUSE;
    assign mt_epc    = mtc0_we && rd == CP0_EPC;

    // mtc0_we is already suppressed on WS_EX/ERET cycles, which gives the
    // exception > eret > mtc0 ordering.
    always_comb begin
        exl_d   = ws_ex ? 1'b1 : eret ? 1'b0 : mt_status ? wdata[1] : exl_q;
        im_d    = mt_status ? wdata[15:8] : im_q;
        ie_d    = mt_status ? wdata[0] : ie_q;
        ip_sw_d = mt_cause ? wdata[9:8] : ip_sw_q;
        epc_d   = ws_ex ? (exl_q ? epc_q : slot ? pc - 32'd4 : pc) : mt_epc ? wdata : epc_q;
        bd_d    = ws_ex && !exl_q ? slot : bd_q;
        exc_d   = ws_ex ? ex_code : exc_q;
        bva_d   = ws_ex && (ex_code == EXC_ADEL || ex_code == EXC_ADES) ? (pc_error ? pc : badvaddr) : bva_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im_q    <= '0;
            exl_q   <= 1'b0;
            ie_q    <= 1'b0;
            ip_sw_q <= '0;
            bd_q    <= 1'b0;
            exc_q   <= '0;
            epc_q   <= '0;
            bva_q   <= '0;
        end else begin
            im_q    <= im_d;
            exl_q   <= exl_d;
            ie_q    <= ie_d;
            ip_sw_q <= ip_sw_d;
            bd_q    <= bd_d;
            exc_q   <= exc_d;
            epc_q   <= epc_d;
            bva_q   <= bva_d;
        end
    end

    // Status keeps BEV (bit 22) hard-wired to 1.
    assign status = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
    // Cause: BD, TI, IP[7] mirrors the timer, IP[1:0] are software bits.
    assign cause  = {bd_q, ti, 14'd0, ti, 5'd0, ip_sw_q, 1'b0, exc_q, 2'd0};

    assign rdata = rd == CP0_STATUS   ? status :
                   rd == CP0_CAUSE    ? cause :
                   rd == CP0_EPC      ? epc_q :
                   rd == CP0_BADVADDR ? bva_q :
                   rd == CP0_COUNT    ? count_rd :
                   rd == CP0_COMPARE  ? compare_rd : 32'd0;

    assign epc         = epc_q;
    assign int_pending = |(cause[15:8] & im_q) && ie_q && !exl_q;
endmodule

// File: rtl/wb_stage.sv
// wb_stage: final pipeline stage; GPR write-back, CP0 commit, flush/redirect
// Ports: clk, reset (sync, active-high); ms_to_ws_valid/ms_to_ws_bus in;
// ws_allowin; rf_we/rf_waddr/rf_wdata GPR write; WB_dest/WB_dest_data and
// inst_mfc0_ws for decode dependence/forwarding; WS_EX/ERET flush strobes
// with ws_redirect_pc; int_pending to decode.
// Optional feature: CP0_TIMER_EN (Count/Compare timer inside wb_cp0).
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter logic [31:0] EX_ENTRY = 32'hbfc00380
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ms_to_ws_valid,
    input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic                       ws_allowin,
    output logic                       rf_we,
    output logic [4:0]                 rf_waddr,
    output logic [31:0]                rf_wdata,
    output logic [4:0]                 WB_dest,
    output logic [31:0]                WB_dest_data,
    output logic                       WS_EX,
    output logic                       ERET,
    output logic [31:0]                ws_redirect_pc,
    output logic                       int_pending,
    output logic                       inst_mfc0_ws
);
    ms_bus_t     bus_q, bus_d;
    logic        ws_valid_q, ws_valid_d;
    logic        flush, mtc0_we;
    logic [31:0] cp0_rdata, epc;
    logic        unused_tlb;

    // The stage always completes in one cycle, so it can always accept.
    assign ws_allowin = 1'b1;
    assign WS_EX      = ws_valid_q && bus_q.ex_code != NO_EX;
    assign ERET       = ws_valid_q && bus_q.eret && !WS_EX;
    assign flush      = WS_EX || ERET;
    assign mtc0_we    = ws_valid_q && bus_q.mtc0 && !flush;

    always_comb begin
        ws_valid_d = flush ? 1'b0 : ws_allowin ? ms_to_ws_valid : ws_valid_q;
        bus_d      = ms_to_ws_valid && ws_allowin && !flush ? ms_to_ws_bus : bus_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid_q <= 1'b0;
            bus_q      <= BUS_RST;
        end else begin
            ws_valid_q <= ws_valid_d;
            bus_q      <= bus_d;
        end
    end

    wb_cp0 u_cp0 (
        .clk        (clk),
        .reset      (reset),
        .ws_ex      (WS_EX),
        .eret       (ERET),
        .mtc0_we    (mtc0_we),
        .rd         (bus_q.rd),
        .wdata      (bus_q.final_result),
        .ex_code    (bus_q.ex_code),
        .slot       (bus_q.slot),
        .pc         (bus_q.pc),
        .pc_error   (bus_q.pc_error),
        .badvaddr   (bus_q.badvaddr),
        .rdata      (cp0_rdata),
        .epc        (epc),
        .int_pending(int_pending)
    );

    assign rf_we          = ws_valid_q && bus_q.gr_we && !WS_EX;
    assign rf_waddr       = bus_q.dest;
    assign rf_wdata       = bus_q.mfc0 ? cp0_rdata : bus_q.final_result;
    assign WB_dest        = bus_q.dest & {5{ws_valid_q && bus_q.gr_we}};
    assign WB_dest_data   = rf_wdata;
    assign inst_mfc0_ws   = ws_valid_q && bus_q.mfc0;
    assign ws_redirect_pc = WS_EX ? EX_ENTRY : ERET ? epc : 32'd0;

    // TLB controls ride along for the TLB unit and are not used here.
    assign unused_tlb = bus_q.tlbr ^ bus_q.tlbwi;
endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
    import wb_stage_pkg::*;

    logic        clk = 1'b0, reset = 1'b1, v = 1'b0;
    ms_bus_t     b = BUS_RST;
    logic        ws_allowin, rf_we, WS_EX, ERET, int_pending, inst_mfc0_ws;
    logic [4:0]  rf_waddr, WB_dest;
    logic [31:0] rf_wdata, WB_dest_data, ws_redirect_pc;
    int          checks = 0, failures = 0;

    logic        m_exl, m_ie, m_bd;
    logic [7:0]  m_im;
    logic [1:0]  m_ipsw;
    logic [4:0]  m_exc;
    logic [31:0] m_epc, m_bva;
    logic [4:0]  codes [7] = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};

`ifdef CP0_TIMER_EN
    localparam logic [31:0] TMASK = 32'hbfff_7fff;
`else
    localparam logic [31:0] TMASK = 32'hffff_ffff;
`endif

    wb_stage dut (
        .clk(clk), .reset(reset), .ms_to_ws_valid(v), .ms_to_ws_bus(b),
        .ws_allowin(ws_allowin), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .WB_dest(WB_dest), .WB_dest_data(WB_dest_data), .WS_EX(WS_EX), .ERET(ERET),
        .ws_redirect_pc(ws_redirect_pc), .int_pending(int_pending), .inst_mfc0_ws(inst_mfc0_ws)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] rd);
        case (rd)
            5'd8:    return m_bva;
            5'd12:   return {9'd0, 1'b1, 6'd0, m_im, 6'd0, m_exl, m_ie};
            5'd13:   return {m_bd, 15'd0, 6'd0, m_ipsw, 1'b0, m_exc, 2'd0};
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_int();
        return |({6'd0, m_ipsw} & m_im) && m_ie && !m_exl;
    endfunction

    task automatic m_commit(input ms_bus_t x);
        if (x.ex_code != NO_EX) begin
            if (!m_exl) begin
                m_epc = x.slot ? x.pc - 4 : x.pc;
                m_bd  = x.slot;
            end
            m_exl = 1'b1;
            m_exc = x.ex_code;
            if (x.ex_code == 5'd4 || x.ex_code == 5'd5) m_bva = x.pc_error ? x.pc : x.badvaddr;
        end else if (x.eret) begin
            m_exl = 1'b0;
        end else if (x.mtc0) begin
            if (x.rd == 5'd12) begin
                m_im  = x.final_result[15:8];
                m_exl = x.final_result[1];
                m_ie  = x.final_result[0];
            end else if (x.rd == 5'd13) begin
                m_ipsw = x.final_result[9:8];
            end else if (x.rd == 5'd14) begin
                m_epc = x.final_result;
            end
        end
    endtask

    task automatic drive(input ms_bus_t x);
        @(negedge clk);
        b = x;
        v = 1'b1;
        @(posedge clk);
        #1 v = 1'b0;
    endtask

    task automatic step(input ms_bus_t x);
        logic        ex, er;
        logic [31:0] wd, cm;
        drive(x);
        ex = x.ex_code != NO_EX;
        er = x.eret && !ex;
        wd = x.mfc0 ? m_read(x.rd) : x.final_result;
        cm = x.mfc0 && x.rd == 5'd13 ? TMASK : 32'hffff_ffff;
        chk("ws_ex", WS_EX, ex);
        chk("eret", ERET, er);
        chk("rf_we", rf_we, x.gr_we && !ex);
        chk("rf_waddr", rf_waddr, x.dest);
        chk("rf_wdata", rf_wdata & cm, wd & cm);
        chk("wb_dest_data", WB_dest_data & cm, wd & cm);
        chk("wb_dest", WB_dest, x.gr_we ? x.dest : 5'd0);
        chk("inst_mfc0_ws", inst_mfc0_ws, x.mfc0);
        chk("redirect", ws_redirect_pc, ex ? 32'hbfc00380 : er ? m_epc : 32'd0);
        m_commit(x);
        @(posedge clk);
        #1;
        chk("int_pending", int_pending, m_int());
        chk("idle_rf_we", rf_we, 1'b0);
        chk("idle_ws_ex", WS_EX, 1'b0);
    endtask

    function automatic ms_bus_t nop();
        return BUS_RST;
    endfunction

    function automatic logic [4:0] rd_ok(input logic [4:0] r);
`ifdef CP0_TIMER_EN
        return r == 5'd9 || r == 5'd11 ? 5'd12 : r;
`else
        return r;
`endif
    endfunction

    function automatic ms_bus_t rnd();
        ms_bus_t      x;
        logic [127:0] r;
        int           k;
        r = {$urandom, $urandom, $urandom, $urandom};
        x = r[118:0];
        x.ex_code = NO_EX;
        x.eret = 1'b0;
        x.mtc0 = 1'b0;
        x.mfc0 = 1'b0;
        x.pc[1:0] = 2'b00;
        k = $urandom_range(0, 5);
        if (k == 1) begin
            x.mfc0 = 1'b1;
            x.rd = rd_ok(x.rd);
        end else if (k == 2) begin
            x.mtc0 = 1'b1;
            k = $urandom_range(0, 3);
            x.rd = rd_ok(k == 0 ? 5'd12 : k == 1 ? 5'd13 : k == 2 ? 5'd14 : x.rd);
            if (x.rd == 5'd12) x.final_result[15] = 1'b0;
        end else if (k == 3) begin
            x.ex_code = codes[$urandom_range(0, 6)];
        end else if (k == 4) begin
            x.eret = 1'b1;
        end
        return x;
    endfunction

    initial begin
        ms_bus_t x;
        logic [31:0] c1;
        m_exl = 0; m_ie = 0; m_bd = 0; m_im = 0; m_ipsw = 0; m_exc = 0; m_epc = 0; m_bva = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_ws_ex", WS_EX, 0);
        chk("rst_eret", ERET, 0);
        chk("rst_redirect", ws_redirect_pc, 0);
        chk("rst_wb_dest", WB_dest, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_int", int_pending, 0);
        chk("rst_mfc0", inst_mfc0_ws, 0);
        chk("allowin", ws_allowin, 1);
        reset = 1'b0;

        x = nop(); x.mfc0 = 1; x.gr_we = 1; x.dest = 5'd2; x.rd = 5'd12; step(x);
        chk("status_reset", m_read(5'd12), 32'h0040_0000);

        x = nop(); x.pc = 32'hbfc00010; x.dest = 5'd5; x.gr_we = 1; x.final_result = 32'h1234; step(x);

        x = nop(); x.pc = 32'h80; x.gr_we = 1; x.dest = 5'd3; x.ex_code = EXC_SYS; step(x);
        chk("sys_epc", m_epc, 32'h80);
        for (int r = 12; r <= 14; r++) begin
            x = nop(); x.mfc0 = 1; x.gr_we = 1; x.rd = 5'(r); step(x);
        end
        x = nop(); x.eret = 1; step(x);

        x = nop(); x.pc = 32'h104; x.slot = 1; x.badvaddr = 32'h1001; x.ex_code = EXC_ADEL; step(x);
        foreach (codes[i]) if (i < 3) begin
            x = nop(); x.mfc0 = 1; x.gr_we = 1; x.rd = i == 0 ? 5'd14 : i == 1 ? 5'd13 : 5'd8; step(x);
        end
        x = nop(); x.pc = 32'h200; x.ex_code = EXC_OV; step(x);
        x = nop(); x.mfc0 = 1; x.gr_we = 1; x.rd = 5'd14; step(x);
        x = nop(); x.mfc0 = 1; x.gr_we = 1; x.rd = 5'd13; step(x);
        x = nop(); x.eret = 1; step(x);

        x = nop(); x.mtc0 = 1; x.rd = 5'd14; x.final_result = 32'h2000; step(x);
        x = nop(); x.eret = 1; step(x);
        x = nop(); x.mfc0 = 1; x.gr_we = 1; x.rd = 5'd12; step(x);

        x = nop(); x.mtc0 = 1; x.rd = 5'd12; x.final_result = 32'h0000_0301; step(x);
        x = nop(); x.mtc0 = 1; x.rd = 5'd13; x.final_result = 32'h0000_0100; step(x);
        chk("int_set", int_pending, 1);
        x = nop(); x.mtc0 = 1; x.rd = 5'd12; x.final_result = 32'h0000_0303; step(x);
        chk("int_exl", int_pending, 0);

        // exception followed back-to-back by a valid bundle: the bundle is dropped
        x = nop(); x.pc = 32'h300; x.ex_code = EXC_BP;
        @(negedge clk);
        b = x;
        v = 1'b1;
        @(posedge clk);
        #1;
        x = nop(); x.gr_we = 1; x.dest = 5'd7; x.final_result = 32'h77;
        b = x;
        chk("flush_ws_ex", WS_EX, 1);
        m_commit(b.ex_code == NO_EX ? ms_bus_t'({42'd0, EXC_BP, 40'd0, 32'h300}) : b);
        @(posedge clk);
        #1 v = 1'b0;
        chk("blocked_rf_we", rf_we, 0);
        chk("blocked_wb_dest", WB_dest, 0);
        @(posedge clk);
        #1;
        x = nop(); x.mfc0 = 1; x.gr_we = 1; x.rd = 5'd14; step(x);

`ifdef CP0_TIMER_EN
        x = nop(); x.mtc0 = 1; x.rd = 5'd11; x.final_result = 32'd4; drive(x);
        x.rd = 5'd9; x.final_result = 32'd0; drive(x);
        repeat (12) @(posedge clk);
        x = nop(); x.mfc0 = 1; x.gr_we = 1; x.rd = 5'd13; drive(x);
        chk("timer_ti_set", rf_wdata[30], 1);
        x = nop(); x.mtc0 = 1; x.rd = 5'd11; x.final_result = 32'hffff_0000; drive(x);
        x = nop(); x.mfc0 = 1; x.gr_we = 1; x.rd = 5'd13; drive(x);
        chk("timer_ti_clr", rf_wdata[30], 0);
        x.rd = 5'd9; drive(x);
        c1 = rf_wdata;
        repeat (4) @(posedge clk);
        drive(x);
        chk("count_runs", (rf_wdata - c1) inside {32'd2, 32'd3}, 1);
        @(posedge clk);
        #1;
`endif

        repeat (400) step(rnd());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
